mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of valid data-memory words; legal addresses are 0..MEM_DEPTH-1.
REQ-002 The block SHALL have parameter TIMEOUT, default 8, range 1..15, meaning the maximum number of WAIT cycles without dmem_ack.
REQ-003 Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX/MEM register holds a live instruction
- writeback_enable  in  1  instruction writes the register file
- mem_read_enable  in  1  load
- mem_write_enable  in  1  store
- instruction_dest  in  4  destination register
- alu_result  in  24  ALU result; memory address for load/store
- store_data  in  24  store payload
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  24  memory address
- dmem_wdata  out  24  write data
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  24  read data, valid when dmem_ack=1
- stall  out  1  freeze upstream stages and EX/MEM register
- writeback_enable_out, mem_read_enable_out  out  1 each  to MEM/WB register
- instruction_dest_out  out  4  to MEM/WB register
- alu_result_out, mem_read_data_out  out  24 each  to MEM/WB register
- bus_error  out  1  sticky error flag

Function
REQ-004 The FSM SHALL have exactly the states IDLE, WAIT and DONE.
REQ-005 A memory operation SHALL be in_valid=1 with exactly one of mem_read_enable or mem_write_enable set.
REQ-006 In IDLE, a memory operation with alu_result < MEM_DEPTH SHALL latch alu_result, store_data, the write flag, writeback_enable, mem_read_enable and instruction_dest; clear the timeout counter; assert stall combinationally; and transition to WAIT.
REQ-007 In IDLE, with no memory operation pending, the block SHALL pass the input fields combinationally to the *_out ports, gated by in_valid, with stall=0 and mem_read_data_out=0.
REQ-008 In IDLE, an illegal operation SHALL raise bus_error at the next edge, issue no request, drive stall=0 and writeback_enable_out=0, and remain in IDLE.
- Illegal = both enables set, or a memory operation with alu_result >= MEM_DEPTH.
REQ-009 In WAIT, the block SHALL drive dmem_req=1 with dmem_addr, dmem_we and dmem_wdata taken from the latched values, stable every cycle, and SHALL drive stall=1.
REQ-010 In WAIT, dmem_ack=1 SHALL capture dmem_rdata into the read-data register (reads only) and transition to DONE.
REQ-011 In WAIT without dmem_ack, the counter SHALL increment; when the counter equals TIMEOUT-1, the block SHALL set bus_error and an abort flag, transition to DONE, and deassert dmem_req.
REQ-012 In DONE, the block SHALL drive stall=0 and dmem_req=0 and present the latched fields.
- mem_read_data_out = captured data.
- writeback_enable_out = latched writeback_enable AND NOT abort.
- Next state is IDLE unconditionally.
REQ-013 While stall=1, writeback_enable_out and mem_read_enable_out SHALL be 0, so a bubble enters MEM/WB.
REQ-014 Outside WAIT, dmem_req SHALL be 0 and dmem_addr, dmem_we and dmem_wdata SHALL be 0.
REQ-015 dmem_ack outside WAIT SHALL be ignored.
REQ-016 bus_error SHALL stay set until reset.
REQ-017 Minimum memory-operation latency SHALL be 3 cycles (IDLE, WAIT with ack, DONE), with stall high for 2 cycles.

Reset
REQ-018 rst=1 SHALL immediately force the state to IDLE, dmem_req=0, the counter to 0, the abort flag to 0, bus_error=0, all latched and captured registers to 0, and stall=0, including when reset is asserted mid-WAIT.
REQ-019 After rst falls, the first rising edge SHALL evaluate the IDLE rules.

Verification
V1 Non-memory op: in_valid=1, writeback_enable=1, instruction_dest=5, alu_result=0x00002A -> same cycle: stall=0, writeback_enable_out=1, alu_result_out=0x00002A, dmem_req=0.
V2 Load, addr 0x10, ack on the 2nd WAIT cycle with rdata 0xABCDEF -> stall high 3 cycles; DONE shows mem_read_data_out=0xABCDEF, mem_read_enable_out=1, writeback_enable_out=1.
V3 Store, addr 0x20, data 0x123456, ack on the 1st WAIT cycle -> dmem_we=1, dmem_addr=0x20, dmem_wdata=0x123456 for one cycle; bus_error=0.
V4 Load, no ack, TIMEOUT=8 -> dmem_req high 8 cycles; bus_error=1; DONE shows writeback_enable_out=0.
V5 Load at addr 0x100 with MEM_DEPTH=256 -> no dmem_req, stall=0, bus_error=1 next cycle; separately, both enables set -> same result.
V6 rst pulsed on the 3rd WAIT cycle -> dmem_req=0 and stall=0 immediately; late ack is ignored; state is IDLE.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Pipeline-side and data-memory-side signals of the memory-access stage.
interface mem_access_stage_if;
    logic        in_valid;
    logic        writeback_enable;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [3:0]  instruction_dest;
    logic [23:0] alu_result;
    logic [23:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [23:0] dmem_addr;
    logic [23:0] dmem_wdata;
    logic        dmem_ack;
    logic [23:0] dmem_rdata;
    logic        stall;
    logic        writeback_enable_out;
    logic        mem_read_enable_out;
    logic [3:0]  instruction_dest_out;
    logic [23:0] alu_result_out;
    logic [23:0] mem_read_data_out;
    logic        bus_error;

    modport master (
        input  in_valid, writeback_enable, mem_read_enable, mem_write_enable,
               instruction_dest, alu_result, store_data, dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, stall,
               writeback_enable_out, mem_read_enable_out, instruction_dest_out,
               alu_result_out, mem_read_data_out, bus_error
    );

    modport slave (
        output in_valid, writeback_enable, mem_read_enable, mem_write_enable,
               instruction_dest, alu_result, store_data, dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, stall,
               writeback_enable_out, mem_read_enable_out, instruction_dest_out,
               alu_result_out, mem_read_data_out, bus_error
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one load/store per instruction to data memory, sticky bus_error on faults.
// Non-memory ops pass through in 0 cycles; memory ops take >=3 cycles with stall high from issue to completion.
module mem_access_stage #(
    parameter int MEM_DEPTH = 256,
    parameter int TIMEOUT   = 8
) (
    input logic                clk,
    input logic                rst,
    mem_access_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [24:0] DEPTH_LIM = 25'(MEM_DEPTH);
    localparam logic [3:0]  CNT_LAST  = 4'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [23:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  dest_q, cnt_q;
    logic        we_q, wb_q, rd_q, abort_q, err_q;
    logic        mem_op, in_range, legal_op, illegal_op, stall_c;

    assign mem_op     = bus.in_valid && (bus.mem_read_enable ^ bus.mem_write_enable);
    assign in_range   = {1'b0, bus.alu_result} < DEPTH_LIM;
    assign legal_op   = mem_op && in_range;
    assign illegal_op = (bus.in_valid && bus.mem_read_enable && bus.mem_write_enable)
                      || (mem_op && !in_range);

    // Reset must drop stall at once, even while a legal op sits on the inputs.
    assign bus.stall     = stall_c && !rst;
    assign bus.bus_error = err_q;

    always_comb begin
        state_nxt                = state;
        stall_c                  = 1'b0;
        bus.dmem_req             = 1'b0;
        bus.dmem_we              = 1'b0;
        bus.dmem_addr            = '0;
        bus.dmem_wdata           = '0;
        bus.writeback_enable_out = 1'b0;
        bus.mem_read_enable_out  = 1'b0;
        bus.instruction_dest_out = '0;
        bus.alu_result_out       = '0;
        bus.mem_read_data_out    = '0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    bus.instruction_dest_out = bus.instruction_dest;
                    bus.alu_result_out       = bus.alu_result;
                end
                if (legal_op) begin
                    stall_c   = 1'b1;
                    state_nxt = WAIT;
                end else if (!illegal_op) begin
                    bus.writeback_enable_out = bus.in_valid && bus.writeback_enable;
                    bus.mem_read_enable_out  = bus.in_valid && bus.mem_read_enable;
                end
            end
            WAIT: begin
                stall_c                  = 1'b1;
                bus.dmem_req             = 1'b1;
                bus.dmem_we              = we_q;
                bus.dmem_addr            = addr_q;
                bus.dmem_wdata           = wdata_q;
                bus.instruction_dest_out = dest_q;
                bus.alu_result_out       = addr_q;
                if (bus.dmem_ack || cnt_q == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.writeback_enable_out = wb_q && !abort_q;
                bus.mem_read_enable_out  = rd_q;
                bus.instruction_dest_out = dest_q;
                bus.alu_result_out       = addr_q;
                bus.mem_read_data_out    = rdata_q;
                state_nxt                = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wb_q    <= 1'b0;
            rd_q    <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (legal_op) begin
                        addr_q  <= bus.alu_result;
                        wdata_q <= bus.store_data;
                        we_q    <= bus.mem_write_enable;
                        wb_q    <= bus.writeback_enable;
                        rd_q    <= bus.mem_read_enable;
                        dest_q  <= bus.instruction_dest;
                        cnt_q   <= '0;
                        abort_q <= 1'b0;
                        rdata_q <= '0;
                    end else if (illegal_op) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.dmem_ack) begin
                        if (!we_q) begin
                            rdata_q <= bus.dmem_rdata;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        abort_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: per-transaction expected cycle traces checked every negedge.
module tb_mem_access_stage;
    localparam int MEM_DEPTH = 256;
    localparam int TIMEOUT   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_stage_if bus();

    mem_access_stage #(.MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall, req, we, wb, mre, err;
        bit          chk_pass, chk_mre, chk_rd;
        logic [23:0] addr, wdata, alu, rd;
        logic [3:0]  dest;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;
    int   checks = 0, errors = 0;
    int   stall_cycles = 0, req_cycles = 0;
    int   txn = 0;
    int   sc, rc;
    bit   exp_err = 1'b0;

    task automatic chk1(input string name, input logic act, input logic expv, input int id);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s txn %0d t=%0t: got %b, want %b", name, id, $time, act, expv);
        end
    endtask

    task automatic chk24(input string name, input logic [23:0] act, input logic [23:0] expv, input int id);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s txn %0d t=%0t: got %h, want %h", name, id, $time, act, expv);
        end
    endtask

    // Single compare process: one expected record per clock cycle.
    always @(negedge clk) begin
        if (bus.stall === 1'b1) stall_cycles++;
        if (bus.dmem_req === 1'b1) req_cycles++;
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk1("stall", bus.stall, ce.stall, ce.id);
            chk1("dmem_req", bus.dmem_req, ce.req, ce.id);
            chk1("dmem_we", bus.dmem_we, ce.we, ce.id);
            chk24("dmem_addr", bus.dmem_addr, ce.addr, ce.id);
            chk24("dmem_wdata", bus.dmem_wdata, ce.wdata, ce.id);
            chk1("writeback_enable_out", bus.writeback_enable_out, ce.wb, ce.id);
            chk1("bus_error", bus.bus_error, ce.err, ce.id);
            if (ce.chk_mre) chk1("mem_read_enable_out", bus.mem_read_enable_out, ce.mre, ce.id);
            if (ce.chk_pass) begin
                chk24("instruction_dest_out", 24'(bus.instruction_dest_out), 24'(ce.dest), ce.id);
                chk24("alu_result_out", bus.alu_result_out, ce.alu, ce.id);
            end
            if (ce.chk_rd) chk24("mem_read_data_out", bus.mem_read_data_out, ce.rd, ce.id);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input bit wb, input bit mre, input bit mwe,
                         input logic [3:0] dest, input logic [23:0] alu, input logic [23:0] sd,
                         input bit ack, input logic [23:0] rdv);
        bus.in_valid         = iv;
        bus.writeback_enable = wb;
        bus.mem_read_enable  = mre;
        bus.mem_write_enable = mwe;
        bus.instruction_dest = dest;
        bus.alu_result       = alu;
        bus.store_data       = sd;
        bus.dmem_ack         = ack;
        bus.dmem_rdata       = rdv;
    endtask

    function automatic exp_t blank();
        exp_t e = '{default: 0};
        return e;
    endfunction

    task automatic push(input exp_t e);
        e.id  = txn;
        e.err = exp_err;
        exp_q.push_back(e);
    endtask

    // Non-memory instruction: one cycle, fields pass through gated by in_valid.
    task automatic do_plain(input bit iv, input bit wb, input bit mre, input logic [3:0] dest,
                            input logic [23:0] alu);
        exp_t e = blank();
        step();
        txn++;
        drive(iv, wb, iv ? 1'b0 : mre, 1'b0, dest, alu, 24'($urandom),
              1'($urandom_range(0, 1)), 24'($urandom));
        e.wb       = iv & wb;
        e.chk_mre  = 1'b1;
        e.chk_pass = 1'b1;
        e.chk_rd   = 1'b1;
        e.dest     = iv ? dest : 4'd0;
        e.alu      = iv ? alu : 24'd0;
        push(e);
    endtask

    // Legal load/store; ack_at = WAIT cycle carrying ack (outside 1..TIMEOUT means no ack).
    task automatic do_mem(input bit is_wr, input bit wb, input logic [3:0] dest,
                          input logic [23:0] addr, input logic [23:0] sd, input int ack_at,
                          input logic [23:0] rdv, output int n_stall, output int n_req);
        exp_t e;
        bit   acked = (ack_at >= 1 && ack_at <= TIMEOUT);
        int   n     = acked ? ack_at : TIMEOUT;
        step();
        txn++;
        stall_cycles = 0;
        req_cycles   = 0;
        drive(1'b1, wb, !is_wr, is_wr, dest, addr, sd, 1'($urandom_range(0, 1)), 24'($urandom));
        e = blank();
        e.stall   = 1'b1;
        e.chk_mre = 1'b1;
        push(e);
        for (int i = 1; i <= n; i++) begin
            step();
            bus.dmem_ack   = acked && (i == ack_at);
            bus.dmem_rdata = (acked && i == ack_at) ? rdv : 24'($urandom);
            e = blank();
            e.stall   = 1'b1;
            e.req     = 1'b1;
            e.we      = is_wr;
            e.addr    = addr;
            e.wdata   = sd;
            e.chk_mre = 1'b1;
            push(e);
        end
        if (!acked) exp_err = 1'b1;
        step();
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = 24'($urandom);
        e = blank();
        e.wb       = wb & acked;
        e.mre      = !is_wr;
        e.chk_mre  = 1'b1;
        e.chk_pass = 1'b1;
        e.dest     = dest;
        e.alu      = addr;
        e.chk_rd   = acked && !is_wr;
        e.rd       = rdv;
        push(e);
        @(negedge clk);
        #1;
        n_stall = stall_cycles;
        n_req   = req_cycles;
    endtask

    task automatic do_illegal(input bit both, input logic [23:0] addr);
        exp_t e = blank();
        bit   ld = 1'($urandom_range(0, 1));
        step();
        txn++;
        drive(1'b1, 1'b1, both ? 1'b1 : ld, both ? 1'b1 : !ld, 4'($urandom), addr,
              24'($urandom), 1'($urandom_range(0, 1)), 24'($urandom));
        push(e);
        exp_err = 1'b1;
    endtask

    task automatic do_reset();
        exp_t e = blank();
        e.chk_mre  = 1'b1;
        e.chk_pass = 1'b1;
        e.chk_rd   = 1'b1;
        step();
        txn++;
        rst     = 1'b1;
        exp_err = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 1'b1, 24'hFFFFFF);
        push(e);
        step();
        txn++;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 1'b0, 24'd0);
        push(e);
    endtask

    initial begin
        exp_t e;
        int   r;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 1'b0, 24'd0);
        do_reset();

        // V1: non-memory op passes straight through.
        do_plain(1'b1, 1'b1, 1'b0, 4'd5, 24'h00002A);
        // V2: load, ack on 2nd WAIT cycle.
        do_mem(1'b0, 1'b1, 4'd7, 24'h000010, 24'h0, 2, 24'hABCDEF, sc, rc);
        chk24("v2_stall_cycles", 24'(sc), 24'd3, txn);
        chk24("v2_req_cycles", 24'(rc), 24'd2, txn);
        // V3: store, ack on 1st WAIT cycle.
        do_mem(1'b1, 1'b0, 4'd2, 24'h000020, 24'h123456, 1, 24'h0, sc, rc);
        chk24("v3_req_cycles", 24'(rc), 24'd1, txn);
        // Ack on the last allowed WAIT cycle still completes; top legal address.
        do_mem(1'b0, 1'b1, 4'd1, 24'(MEM_DEPTH - 1), 24'h0, TIMEOUT, 24'h13579B, sc, rc);
        chk24("late_ack_req_cycles", 24'(rc), 24'(TIMEOUT), txn);
        do_plain(1'b0, 1'b1, 1'b1, 4'd3, 24'h000ABC);
        // V4: load never acked.
        do_mem(1'b0, 1'b1, 4'd9, 24'h000030, 24'h0, 0, 24'h0, sc, rc);
        chk24("v4_req_cycles", 24'(rc), 24'd8, txn);
        chk24("v4_stall_cycles", 24'(sc), 24'd9, txn);
        do_plain(1'b1, 1'b0, 1'b0, 4'd4, 24'h000100);
        // V5: out-of-range load, then both enables.
        do_reset();
        do_illegal(1'b0, 24'(MEM_DEPTH));
        do_plain(1'b1, 1'b1, 1'b0, 4'd6, 24'h000077);
        do_reset();
        do_illegal(1'b1, 24'h000008);
        do_plain(1'b1, 1'b1, 1'b0, 4'd6, 24'h000078);

        // V6: reset on 3rd WAIT cycle, ack arrives afterwards.
        step();
        txn++;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 24'h000040, 24'd0, 1'b0, 24'd0);
        e = blank(); e.stall = 1'b1; e.chk_mre = 1'b1; push(e);
        for (int i = 0; i < 2; i++) begin
            step();
            e = blank(); e.stall = 1'b1; e.req = 1'b1; e.addr = 24'h000040; e.chk_mre = 1'b1;
            push(e);
        end
        step();
        rst     = 1'b1;
        exp_err = 1'b0;
        e = blank(); e.chk_mre = 1'b1; push(e);
        e = blank(); e.chk_mre = 1'b1; e.chk_pass = 1'b1; e.chk_rd = 1'b1;
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 1'b1, 24'h5A5A5A);
        push(e);
        step();
        rst = 1'b0;
        push(e);
        do_plain(1'b1, 1'b1, 1'b0, 4'd8, 24'h000099);

        do_reset();
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                do_plain(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 4'($urandom), 24'($urandom));
            end else if (r <= 8) begin
                do_mem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                       24'($urandom_range(0, MEM_DEPTH - 1)), 24'($urandom),
                       $urandom_range(0, TIMEOUT + 1), 24'($urandom), sc, rc);
            end else if ($urandom_range(0, 1) == 1) begin
                do_illegal(1'b0, 24'($urandom_range(24'hFFFFFF, MEM_DEPTH)));
            end else begin
                do_illegal(1'b1, 24'($urandom));
            end
        end

        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 1'b0, 24'd0);
        @(negedge clk);
        #1;
        chk24("queue_drained", 24'(exp_q.size()), 24'd0, txn);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
